// File: rtl/uart_pkg.sv
// Shared definitions for the host-link UART receiver and transmitter.
// Contents: receiver state type, data-bit count, stop-bit count, and a 2-of-3 majority helper.
// No ports; imported with `import uart_pkg::*;`.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  // The transmitter sends this many stop bits. The receiver checks the first one only.
  localparam int UART_STOP_BITS = 1;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_IDLE = 3'd4
  } uart_rx_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser that brings an asynchronous level into the clock domain.
// Latency: 2 cycles. Backpressure: none.
// Ports: clock, reset (sync, active-high), d_in (async), d_out (synchronised).
// RESET_VAL sets the value both flops take on reset.
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d_in,
  output logic d_out
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d_in;
    sync_d = meta_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign d_out = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first. It delivers a byte with a one-cycle rx_ready strobe, or a one-cycle ferr strobe when framing fails.
// Latency: rx_ready/ferr is high in the cycle after the stop-bit sample, which is t0 + 19*CLOCK_PER_HALF_BIT (+1 with majority voting).
// Backpressure: none. rdata holds the byte until the next good frame.
// Ports: clock, reset (sync, active-high), rxd_orig (async line, idle high),
//        rx_ready (pulse), rdata[7:0] (last good byte), ferr (pulse).
// Option: define UART_RX_MAJORITY_EN to take a 2-of-3 vote around every bit centre.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCK_PER_HALF_BIT = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rxd_orig,
  output logic       rx_ready,
  output logic [7:0] rdata,
  output logic       ferr
);

  localparam int CW = $clog2(2 * CLOCK_PER_HALF_BIT);
  localparam logic [CW-1:0] BIT_LOAD = CW'(2 * CLOCK_PER_HALF_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
  // The vote finishes at centre+1, so the first interval is one cycle longer.
  // Later intervals keep that same offset.
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLOCK_PER_HALF_BIT);
`else
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLOCK_PER_HALF_BIT - 1);
`endif

  logic rxs;

  uart_sync #(.RESET_VAL(1'b1)) u_sync (
    .clock (clock),
    .reset (reset),
    .d_in  (rxd_orig),
    .d_out (rxs)
  );

  logic samp;

`ifdef UART_RX_MAJORITY_EN
  // rxs history: hist1 is one cycle old and hist2 is two cycles old.
  // Together with rxs they form the voting window.
  logic hist1_q, hist1_d;
  logic hist2_q, hist2_d;

  always_comb begin
    hist1_d = rxs;
    hist2_d = hist1_q;
    samp    = maj3(rxs, hist1_q, hist2_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hist1_q <= 1'b1;
      hist2_q <= 1'b1;
    end else begin
      hist1_q <= hist1_d;
      hist2_q <= hist2_d;
    end
  end
`else
  assign samp = rxs;
`endif

  uart_rx_state_t state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     idx_q, idx_d;
  logic [7:0]     shreg_q, shreg_d;
  logic [7:0]     rdata_q, rdata_d;
  logic           rdy_q, rdy_d;
  logic           ferr_q, ferr_d;
  logic           tick;

  assign tick = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    rdata_d = rdata_q;
    rdy_d   = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      RX_IDLE: begin
        if (!rxs) begin
          state_d = RX_START;
          cnt_d   = HALF_LOAD;
        end
      end

      RX_START: begin
        if (tick) begin
          if (samp) begin
            // The line went high again before the start-bit centre.
            // Treat the low pulse as a glitch.
            state_d = RX_IDLE;
          end else begin
            state_d = RX_DATA;
            idx_d   = '0;
            cnt_d   = BIT_LOAD;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      RX_DATA: begin
        if (tick) begin
          shreg_d[idx_q] = samp;
          cnt_d          = BIT_LOAD;
          if (idx_q == 3'(UART_DATA_BITS - 1)) begin
            state_d = RX_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      RX_STOP: begin
        if (tick) begin
          // Return to idle at the stop-bit centre.
          // This lets a start edge at the end of the stop bit be caught.
          if (samp) begin
            rdata_d = shreg_q;
            rdy_d   = 1'b1;
            state_d = RX_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = RX_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      RX_WAIT_IDLE: begin
        // Wait for the line to go high so a break does not look like a stream of zero frames.
        if (rxs) begin
          state_d = RX_IDLE;
        end
      end

      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      rdata_q <= '0;
      rdy_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      rdata_q <= rdata_d;
      rdy_q   <= rdy_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_ready = rdy_q;
  assign rdata    = rdata_q;
  assign ferr     = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx with CLOCK_PER_HALF_BIT=10 (20-clock bits, 10 ns clock).
// Frames are driven 1 ns after a clock edge E. The FSM first acts on the low start bit at edge t0 = E+3.
// The rx_ready/ferr pulse is therefore seen at cycle E+3+190 (one later with majority voting).
module tb_uart_rx;

  localparam int H   = 10;
  localparam int BIT = 2 * H;
`ifdef UART_RX_MAJORITY_EN
  localparam int LAT = 3 + 19 * H + 1;
`else
  localparam int LAT = 3 + 19 * H;
`endif

  logic       clock    = 1'b0;
  logic       reset    = 1'b1;
  logic       rxd_orig = 1'b1;
  logic       rx_ready;
  logic       ferr;
  logic [7:0] rdata;

  uart_rx #(.CLOCK_PER_HALF_BIT(H)) dut (
    .clock    (clock),
    .reset    (reset),
    .rxd_orig (rxd_orig),
    .rx_ready (rx_ready),
    .rdata    (rdata),
    .ferr     (ferr)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Output monitor.
  int         rdy_cnt = 0;
  int         ferr_cnt = 0;
  int         both_cnt = 0;
  int         last_ferr_cyc = 0;
  int         rdy_cyc_q[$];
  logic [7:0] rdy_dat_q[$];

  always @(negedge clock) begin
    if (rx_ready) begin
      rdy_cnt++;
      rdy_cyc_q.push_back(cyc);
      rdy_dat_q.push_back(rdata);
    end
    if (ferr) begin
      ferr_cnt++;
      last_ferr_cyc = cyc;
    end
    if (rx_ready && ferr) both_cnt++;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Drives one frame: start bit, 8 data bits (LSB first), then the stop bit.
  // spike: in-bit cycle offset that is inverted in every bit (-1 for none).
  // rst_bit: frame bit (0 is the start bit) whose mid cycle pulses reset (-1 for none).
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int spike,
                            input int rst_bit, output int fall);
    logic [9:0] bits;
    bits = {stop_v, b, 1'b0};
    fall = 0;
    for (int j = 0; j < 10; j++) begin
      for (int k = 0; k < BIT; k++) begin
        @(posedge clock);
        #1;
        if (j == 0 && k == 0) fall = cyc;
        rxd_orig = (k == spike) ? ~bits[j] : bits[j];
        reset    = (j == rst_bit) && (k == 10);
      end
    end
  endtask

  int f0, f1, r0, e0;

  initial begin
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_rdata", rdata, 8'h00);
    check("rst_rx_ready", rx_ready, 1'b0);
    check("rst_ferr", ferr, 1'b0);
    idle(20);

    // Single byte 0x99.
    r0 = rdy_cnt; e0 = ferr_cnt;
    send_frame(8'h99, 1'b1, -1, -1, f0);
    idle(20);
    check("b99_count", rdy_cnt - r0, 1);
    check("b99_time", rdy_cyc_q[r0], f0 + LAT);
    check("b99_data", rdy_dat_q[r0], 8'h99);
    check("b99_rdata", rdata, 8'h99);
    check("b99_no_ferr", ferr_cnt - e0, 0);

    // Back-to-back 0xaa, 0x55 with no idle gap.
    r0 = rdy_cnt;
    send_frame(8'haa, 1'b1, -1, -1, f0);
    send_frame(8'h55, 1'b1, -1, -1, f1);
    idle(20);
    check("b2b_count", rdy_cnt - r0, 2);
    check("b2b_time0", rdy_cyc_q[r0], f0 + LAT);
    check("b2b_gap", rdy_cyc_q[r0+1] - rdy_cyc_q[r0], 10 * BIT);
    check("b2b_data0", rdy_dat_q[r0], 8'haa);
    check("b2b_data1", rdy_dat_q[r0+1], 8'h55);

    // 5-clock low glitch on the idle line, then 0x3c.
    r0 = rdy_cnt; e0 = ferr_cnt;
    @(posedge clock); #1 rxd_orig = 1'b0;
    idle(5);
    rxd_orig = 1'b1;
    idle(60);
    check("glitch_no_rdy", rdy_cnt - r0, 0);
    check("glitch_no_ferr", ferr_cnt - e0, 0);
    send_frame(8'h3c, 1'b1, -1, -1, f0);
    idle(20);
    check("b3c_count", rdy_cnt - r0, 1);
    check("b3c_data", rdata, 8'h3c);

    // Bad stop bit, then the line held low as a break.
    r0 = rdy_cnt; e0 = ferr_cnt;
    send_frame(8'h55, 1'b0, -1, -1, f0);
    idle(20);
    check("ferr_count", ferr_cnt - e0, 1);
    check("ferr_time", last_ferr_cyc, f0 + LAT);
    check("ferr_no_rdy", rdy_cnt - r0, 0);
    check("ferr_rdata_kept", rdata, 8'h3c);
    idle(3000);
    check("break_no_ferr", ferr_cnt - e0, 1);
    check("break_no_rdy", rdy_cnt - r0, 0);
    rxd_orig = 1'b1;
    idle(40);
    send_frame(8'h12, 1'b1, -1, -1, f0);
    idle(20);
    check("b12_count", rdy_cnt - r0, 1);
    check("b12_data", rdata, 8'h12);

    // Reset pulse during data bit 3, then a complete 0xff.
    r0 = rdy_cnt; e0 = ferr_cnt;
    send_frame(8'hff, 1'b1, -1, 4, f0);
    idle(20);
    check("midrst_rdata", rdata, 8'h00);
    check("midrst_no_rdy", rdy_cnt - r0, 0);
    check("midrst_no_ferr", ferr_cnt - e0, 0);
    send_frame(8'hff, 1'b1, -1, -1, f0);
    idle(20);
    check("bff_count", rdy_cnt - r0, 1);
    check("bff_time", rdy_cyc_q[r0], f0 + LAT);
    check("bff_data", rdata, 8'hff);

`ifdef UART_RX_MAJORITY_EN
    // A one-cycle inverted spike at every bit centre must be voted out.
    r0 = rdy_cnt; e0 = ferr_cnt;
    send_frame(8'ha5, 1'b1, 10, -1, f0);
    idle(20);
    check("maj_count", rdy_cnt - r0, 1);
    check("maj_time", rdy_cyc_q[r0], f0 + LAT);
    check("maj_data", rdata, 8'ha5);
    check("maj_no_ferr", ferr_cnt - e0, 0);
`endif

    check("never_both", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
